// File: rtl/envelope_threshold_detector_pkg.sv
// Shared types and constants for the envelope burst qualifier.
// Provides the FSM state encoding, default qualification counts and a counter-width helper.
package envelope_threshold_detector_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    ACTIVE  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int DEF_ATTACK_CNT = 3;
  localparam int DEF_HOLD_CNT   = 4;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/envelope_threshold_detector_sat_counter.sv
// Saturating up-counter with synchronous load-to-one; load wins over enable.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= WIDTH'(1);
    else if (en && !(&count))
      count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/envelope_threshold_detector.sv
// Burst qualifier for the envelope stream: hysteresis thresholds, attack/hold
// counts, rise/fall events, burst peak and saturating burst length.
module envelope_threshold_detector
  import envelope_threshold_detector_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ATTACK_CNT = DEF_ATTACK_CNT,
  parameter int HOLD_CNT   = DEF_HOLD_CNT,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_en,
  input  logic [DATA_WIDTH-1:0] envelope_in,
  input  logic [DATA_WIDTH-1:0] thr_on,
  input  logic [DATA_WIDTH-1:0] thr_off,
  output logic                  detect,
  output logic                  rise_pulse,
  output logic                  fall_pulse,
  output logic [DATA_WIDTH-1:0] peak_value,
  output logic [LEN_WIDTH-1:0]  burst_len
);

  localparam int CNT_MAX = (ATTACK_CNT > HOLD_CNT) ? ATTACK_CNT : HOLD_CNT;
  localparam int CW      = cnt_width(CNT_MAX);
  localparam logic [CW-1:0] ATK_LAST  = CW'(ATTACK_CNT);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CNT);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          above_on;
  logic          below_off;
  logic          in_burst;
  logic          start;

  always_comb begin
    above_on  = (envelope_in >= thr_on);
    below_off = (envelope_in < thr_off);
    in_burst  = (state == ACTIVE) || (state == RELEASE);
    cnt_inc   = cnt + CW'(1);
    start     = 1'b0;
    if (sample_en) begin
      case (state)
        IDLE:    start = above_on && (ATTACK_CNT == 1);
        ATTACK:  start = above_on && (cnt_inc == ATK_LAST);
        default: start = 1'b0;
      endcase
    end
  end

  // cnt counts qualifying samples while in ATTACK/RELEASE and is cleared on entry to IDLE/ACTIVE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      detect     <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      peak_value <= '0;
    end else begin
      rise_pulse <= start;
      fall_pulse <= 1'b0;
      if (start) begin
        state      <= ACTIVE;
        cnt        <= '0;
        detect     <= 1'b1;
        peak_value <= envelope_in;
      end else if (sample_en) begin
        if (in_burst && (envelope_in > peak_value))
          peak_value <= envelope_in;
        case (state)
          IDLE: begin
            if (above_on) begin
              state <= ATTACK;
              cnt   <= CW'(1);
            end
          end
          ATTACK: begin
            if (above_on) begin
              cnt <= cnt_inc;
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
          ACTIVE: begin
            if (below_off) begin
              if (HOLD_CNT == 1) begin
                state      <= IDLE;
                cnt        <= '0;
                detect     <= 1'b0;
                fall_pulse <= 1'b1;
              end else begin
                state <= RELEASE;
                cnt   <= CW'(1);
              end
            end
          end
          RELEASE: begin
            if (!below_off) begin
              state <= ACTIVE;
              cnt   <= '0;
            end else if (cnt_inc == HOLD_LAST) begin
              state      <= IDLE;
              cnt        <= '0;
              detect     <= 1'b0;
              fall_pulse <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  sat_counter #(.WIDTH(LEN_WIDTH)) u_len (
    .clk   (clk),
    .rst   (rst),
    .load  (start),
    .en    (sample_en && in_burst),
    .count (burst_len)
  );

endmodule

// File: tb/tb_envelope_threshold_detector.sv
// Directed bench for envelope_threshold_detector: vector table plus hand-written
// reset-mid-burst and length-saturation sequences.
module tb_envelope_threshold_detector;

  logic        clk;
  logic        rst;
  logic        sample_en;
  logic [31:0] envelope_in;
  logic [31:0] thr_on;
  logic [31:0] thr_off;

  logic        detect, rise_pulse, fall_pulse;
  logic [31:0] peak_value;
  logic [15:0] burst_len;

  logic        s_detect, s_rise, s_fall;
  logic [31:0] s_peak;
  logic [3:0]  s_len;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        en;
    logic [31:0] env;
    logic        d;
    logic        r;
    logic        f;
    logic [31:0] pk;
    logic [15:0] len;
  } vec_t;

  vec_t vecs[$];

  envelope_threshold_detector #(
    .DATA_WIDTH(32), .ATTACK_CNT(3), .HOLD_CNT(4), .LEN_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .envelope_in(envelope_in),
    .thr_on(thr_on), .thr_off(thr_off), .detect(detect), .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse), .peak_value(peak_value), .burst_len(burst_len)
  );

  envelope_threshold_detector #(
    .DATA_WIDTH(32), .ATTACK_CNT(3), .HOLD_CNT(4), .LEN_WIDTH(4)
  ) dut_sat (
    .clk(clk), .rst(rst), .sample_en(sample_en), .envelope_in(envelope_in),
    .thr_on(thr_on), .thr_off(thr_off), .detect(s_detect), .rise_pulse(s_rise),
    .fall_pulse(s_fall), .peak_value(s_peak), .burst_len(s_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic [31:0] env, input logic d, input logic r,
                     input logic f, input logic [31:0] pk, input logic [15:0] len);
    vec_t v;
    v.en = en; v.env = env; v.d = d; v.r = r; v.f = f; v.pk = pk; v.len = len;
    vecs.push_back(v);
  endtask

  // Inputs change on the falling edge; outputs are read 1 time unit after the rising edge.
  task automatic step(input logic en, input logic [31:0] env);
    @(negedge clk);
    sample_en   = en;
    envelope_in = env;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic d, input logic r, input logic f,
                         input logic [31:0] pk, input logic [15:0] len);
    chk({tag, " detect"}, 32'(detect), 32'(d));
    chk({tag, " rise"},   32'(rise_pulse), 32'(r));
    chk({tag, " fall"},   32'(fall_pulse), 32'(f));
    chk({tag, " peak"},   peak_value, pk);
    chk({tag, " len"},    32'(burst_len), 32'(len));
  endtask

  initial begin
    rst = 1'b1; sample_en = 1'b0; envelope_in = '0;
    thr_on = 32'd1000; thr_off = 32'd600;

    // Attack reject: the 800 breaks the run, neither run reaches 3.
    add(1, 1200, 0,0,0, 0, 0);  add(1, 1200, 0,0,0, 0, 0);  add(1, 800, 0,0,0, 0, 0);
    add(1, 1200, 0,0,0, 0, 0);  add(1, 1200, 0,0,0, 0, 0);  add(1, 0,    0,0,0, 0, 0);
    // Clean burst: attack samples are not part of the burst, so peak/len start at the qualifying 1300.
    add(1, 0,    0,0,0, 0, 0);  add(1, 1200, 0,0,0, 0, 0);  add(1, 1500, 0,0,0, 0, 0);
    add(1, 1300, 1,1,0, 1300, 1); add(1, 900, 1,0,0, 1300, 2); add(1, 500, 1,0,0, 1300, 3);
    add(1, 500,  1,0,0, 1300, 4); add(1, 500, 1,0,0, 1300, 5); add(1, 500, 0,0,1, 1300, 6);
    add(1, 0,    0,0,0, 1300, 6);
    // Hysteresis retrigger: 700 returns to ACTIVE, hold count restarts.
    add(1, 1200, 0,0,0, 1300, 6); add(1, 1500, 0,0,0, 1300, 6); add(1, 1300, 1,1,0, 1300, 1);
    add(1, 500,  1,0,0, 1300, 2); add(1, 500,  1,0,0, 1300, 3); add(1, 700,  1,0,0, 1300, 4);
    add(1, 2000, 1,0,0, 2000, 5); add(1, 100,  1,0,0, 2000, 6); add(1, 100,  1,0,0, 2000, 7);
    add(1, 100,  1,0,0, 2000, 8); add(1, 100,  0,0,1, 2000, 9); add(1, 0,    0,0,0, 2000, 9);
    // sample_en gating with garbage on disabled cycles.
    add(1, 0,            0,0,0, 2000, 9); add(0, 32'hFFFF_FFFF, 0,0,0, 2000, 9);
    add(1, 1200,         0,0,0, 2000, 9); add(0, 32'hFFFF_FFFF, 0,0,0, 2000, 9);
    add(1, 1500,         0,0,0, 2000, 9); add(0, 32'hFFFF_FFFF, 0,0,0, 2000, 9);
    add(1, 1300,         1,1,0, 1300, 1); add(0, 32'hFFFF_FFFF, 1,0,0, 1300, 1);
    add(1, 900,          1,0,0, 1300, 2); add(0, 32'hFFFF_FFFF, 1,0,0, 1300, 2);
    add(1, 500,          1,0,0, 1300, 3); add(0, 32'hFFFF_FFFF, 1,0,0, 1300, 3);
    add(1, 500,          1,0,0, 1300, 4); add(0, 32'hFFFF_FFFF, 1,0,0, 1300, 4);
    add(1, 500,          1,0,0, 1300, 5); add(0, 32'hFFFF_FFFF, 1,0,0, 1300, 5);
    add(1, 500,          0,0,1, 1300, 6); add(0, 32'hFFFF_FFFF, 0,0,0, 1300, 6);
    add(1, 0,            0,0,0, 1300, 6);

    #12;
    chk_all("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].env);
      chk_all($sformatf("vec%0d", i), vecs[i].d, vecs[i].r, vecs[i].f, vecs[i].pk, vecs[i].len);
    end

    // Reset mid-burst while in RELEASE.
    step(1, 1200); step(1, 1500); step(1, 1300);
    chk_all("mid rise", 1, 1, 0, 1300, 1);
    step(1, 1400); step(1, 500);
    chk_all("mid release", 1, 0, 0, 1400, 3);
    #2;
    rst = 1'b1;
    #1;
    chk_all("mid async rst", 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk_all("mid rst held", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    step(1, 1200); step(1, 1500);
    chk_all("requal attack", 0, 0, 0, 0, 0);
    step(1, 1300);
    chk_all("requal rise", 1, 1, 0, 1300, 1);
    step(1, 900);
    chk_all("requal active", 1, 0, 0, 1300, 2);

    // Length saturation on the 4-bit instance.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      int exp_len;
      step(1, 2000);
      exp_len = (k < 3) ? 0 : ((k - 2) > 15 ? 15 : (k - 2));
      chk($sformatf("sat len k%0d", k), 32'(s_len), 32'(exp_len));
    end
    chk("sat detect", 32'(s_detect), 32'd1);
    chk("sat peak", s_peak, 32'd2000);
    chk("wide len", 32'(burst_len), 32'd38);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
